// File: rtl/maze_loc_datapath.sv
// maze_loc_datapath: location datapath for a grid-walking controller.
// Holds the current {X,Y} location, computes the one-step neighbour in a
// given direction with an edge-wrap flag, and keeps a LIFO of visited
// locations that can later be replayed bottom-up.
//
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   rgLd           load nxtLoc into the X/Y registers at the next edge
//   dir            00 Y-1, 01 X+1, 10 X-1, 11 Y+1
//   push, pop      stack push of curLoc / pop (or replay read) onto nxtLoc
//   done           one-cycle pulse that freezes the stack for replay
//   run            replay mode; pop walks the stored path from the bottom
//   adderEn        nxtLoc = curLoc moved one step in dir
//   cntReach       step in dir would wrap past the grid edge (comb)
//   empStck        stack empty / replay exhausted (comb)
//   nxtLoc         next location {X,Y} (comb)
//   curLoc         current location {X,Y} (registered)
module maze_loc_datapath #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rgLd,
  input  logic [1:0] dir,
  input  logic       push,
  input  logic       pop,
  input  logic       done,
  input  logic       run,
  input  logic       adderEn,
  output logic       cntReach,
  output logic       empStck,
  output logic [7:0] nxtLoc,
  output logic [7:0] curLoc
);

  // Pointers carry one extra bit so they can hold the value DEPTH (full).
  localparam int unsigned SPW = PW + 1;

  logic [3:0]     x_q, y_q;
  logic [SPW-1:0] sp_q, sp_d;
  logic [SPW-1:0] rp_q, rp_d;
  logic           frozen_q, frozen_d;
  logic [7:0]     mem [DEPTH];

  logic           sel;
  logic [3:0]     nib;
  logic [3:0]     step;
  logic [3:0]     sum;
  logic [3:0]     edge_chk;
  logic [7:0]     popped;
  logic           push_ok;

  assign curLoc = {x_q, y_q};

  // Direction decode and single-nibble adder.
  assign sel      = dir[1] ^ dir[0];
  assign nib      = sel ? x_q : y_q;
  assign step     = dir[0] ? 4'h1 : 4'hF;
  assign sum      = nib + step;
  assign edge_chk = nib + {3'b000, dir[0]};
  assign cntReach = (edge_chk == 4'h0);

  // Stack read: top of stack while searching, replay pointer once frozen.
  always_comb begin
    popped = 8'h00;
    if (!frozen_q) begin
      if (sp_q != '0) popped = mem[PW'(sp_q - SPW'(1))];
    end else if (rp_q < sp_q) begin
      popped = mem[rp_q[PW-1:0]];
    end
  end

  assign empStck = frozen_q ? (rp_q == sp_q) : (sp_q == '0);

  // Next-location mux; pop has priority over the adder.
  always_comb begin
    nxtLoc = curLoc;
    if (pop) begin
      nxtLoc = popped;
    end else if (adderEn) begin
      nxtLoc = sel ? {sum, y_q} : {x_q, sum};
    end
  end

  assign push_ok = push && !pop && !frozen_q && (sp_q < SPW'(DEPTH));

  // Pointer / freeze next-state.
  always_comb begin
    sp_d     = sp_q;
    rp_d     = rp_q;
    frozen_d = frozen_q;
    if (!frozen_q) begin
      if (pop) begin
        if (sp_q != '0) sp_d = sp_q - SPW'(1);
      end else if (push_ok) begin
        sp_d = sp_q + SPW'(1);
      end
    end else if (run && pop && (rp_q < sp_q)) begin
      rp_d = rp_q + SPW'(1);
    end
    if (done) begin
      frozen_d = 1'b1;
      rp_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_q      <= 4'h0;
      y_q      <= 4'h0;
      sp_q     <= '0;
      rp_q     <= '0;
      frozen_q <= 1'b0;
    end else begin
      if (rgLd) begin
        x_q <= nxtLoc[7:4];
        y_q <= nxtLoc[3:0];
      end
      sp_q     <= sp_d;
      rp_q     <= rp_d;
      frozen_q <= frozen_d;
    end
  end

  // Stack storage; contents need no reset since pointers gate every read.
  always_ff @(posedge clk) begin
    if (push_ok) mem[sp_q[PW-1:0]] <= curLoc;
  end

endmodule

// File: tb/tb_maze_loc_datapath.sv
// Scoreboard bench for maze_loc_datapath: expectations are queued as
// stimulus is driven and compared against the DUT outputs when drained.
module tb_maze_loc_datapath;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rgLd = 1'b0, push = 1'b0, pop = 1'b0;
  logic       done = 1'b0, run = 1'b0, adderEn = 1'b0;
  logic [1:0] dir = 2'b00;
  logic       cntReach, empStck;
  logic [7:0] nxtLoc, curLoc;

  int checks = 0;
  int errors = 0;

  localparam int K_CUR = 0;
  localparam int K_NXT = 1;
  localparam int K_CR  = 2;
  localparam int K_EMP = 3;

  typedef struct {
    string      tag;
    int         kind;
    logic [7:0] val;
  } exp_t;

  exp_t sbq[$];

  maze_loc_datapath #(.DEPTH(256), .PW(8)) dut (
    .clk(clk), .rst(rst), .rgLd(rgLd), .dir(dir), .push(push), .pop(pop),
    .done(done), .run(run), .adderEn(adderEn), .cntReach(cntReach),
    .empStck(empStck), .nxtLoc(nxtLoc), .curLoc(curLoc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic sb(input string tag, input int kind, input logic [7:0] v);
    exp_t e;
    e.tag = tag; e.kind = kind; e.val = v;
    sbq.push_back(e);
  endtask

  // Let combinational outputs settle, then compare everything queued.
  task automatic drain();
    exp_t e;
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      case (e.kind)
        K_CUR:   check(e.tag, curLoc, e.val);
        K_NXT:   check(e.tag, nxtLoc, e.val);
        K_CR:    check(e.tag, {7'b0, cntReach}, e.val);
        default: check(e.tag, {7'b0, empStck}, e.val);
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic ld, input logic ae, input logic [1:0] d,
                     input logic pu, input logic po);
    rgLd = ld; adderEn = ae; dir = d; push = pu; pop = po;
  endtask

  // Asynchronous reset between clock edges.
  task automatic reset_dut();
    cmd(0, 0, 2'b00, 0, 0);
    run = 1'b0; done = 1'b0;
    rst = 1'b0;
    #1;
    sb("rst_cur", K_CUR, 8'h00);
    sb("rst_emp", K_EMP, 8'h01);
    drain();
    rst = 1'b1;
  endtask

  task automatic load_three();
    cmd(1, 1, 2'b11, 1, 0); tick();   // store 00, cur -> 01
    tick();                           // store 01, cur -> 02
    cmd(0, 0, 2'b00, 1, 0); tick();   // store 02
    cmd(0, 0, 2'b00, 0, 0);
    done = 1'b1; tick(); done = 1'b0;
  endtask

  initial begin
    // Reset state
    #3;
    sb("init_cur", K_CUR, 8'h00);
    sb("init_nxt", K_NXT, 8'h00);
    sb("init_emp", K_EMP, 8'h01);
    drain();
    rst = 1'b1;

    // X+1 three times
    cmd(1, 1, 2'b01, 0, 0);
    tick(); sb("mv1", K_CUR, 8'h10); drain();
    tick(); sb("mv2", K_CUR, 8'h20); drain();
    tick(); sb("mv3", K_CUR, 8'h30); sb("mv3_cr", K_CR, 8'h00); drain();

    // Edge flags
    cmd(1, 1, 2'b10, 0, 0);
    repeat (3) tick();
    sb("back_cur", K_CUR, 8'h00); drain();
    cmd(0, 1, 2'b00, 0, 0);
    sb("y0_dec_cr", K_CR, 8'h01); sb("y0_dec_nxt", K_NXT, 8'h0F); drain();
    cmd(1, 1, 2'b10, 0, 0); tick();
    cmd(1, 1, 2'b11, 0, 0); repeat (5) tick();
    sb("f5_cur", K_CUR, 8'hF5); drain();
    cmd(0, 1, 2'b01, 0, 0);
    sb("xf_inc_cr", K_CR, 8'h01); sb("xf_inc_nxt", K_NXT, 8'h05); drain();
    cmd(0, 1, 2'b11, 0, 0);
    sb("y5_inc_cr", K_CR, 8'h00); sb("y5_inc_nxt", K_NXT, 8'hF6); drain();

    // Push 00,10,11 then pop them back in LIFO order
    reset_dut();
    cmd(1, 1, 2'b01, 1, 0); tick();
    cmd(1, 1, 2'b11, 1, 0); tick();
    cmd(0, 0, 2'b00, 1, 0); tick();
    cmd(1, 0, 2'b00, 0, 1);
    sb("lifo_emp0", K_EMP, 8'h00); sb("lifo_nxt0", K_NXT, 8'h11); drain();
    tick(); sb("lifo_cur1", K_CUR, 8'h11); sb("lifo_nxt1", K_NXT, 8'h10); drain();
    tick(); sb("lifo_cur2", K_CUR, 8'h10); sb("lifo_nxt2", K_NXT, 8'h00);
    sb("lifo_emp2", K_EMP, 8'h00); drain();
    tick(); sb("lifo_cur3", K_CUR, 8'h00); sb("lifo_emp3", K_EMP, 8'h01);
    sb("lifo_nxt3", K_NXT, 8'h00); drain();
    tick(); sb("lifo_cur4", K_CUR, 8'h00); sb("lifo_emp4", K_EMP, 8'h01); drain();

    // Simultaneous push and pop at sp=2: pop wins
    reset_dut();
    cmd(1, 1, 2'b11, 1, 0); tick();   // store 00, cur 01
    cmd(1, 1, 2'b11, 1, 0); tick();   // store 01, cur 02
    cmd(0, 0, 2'b00, 1, 1);
    sb("pp_nxt", K_NXT, 8'h01); drain();
    tick();
    cmd(0, 0, 2'b00, 0, 1);
    sb("pp_after_nxt", K_NXT, 8'h00); sb("pp_after_emp", K_EMP, 8'h00); drain();
    tick(); sb("pp_final_emp", K_EMP, 8'h01); drain();

    // Fill to DEPTH, extra push ignored, then drain all
    reset_dut();
    cmd(0, 0, 2'b00, 1, 0);
    repeat (256) tick();
    sb("full_emp", K_EMP, 8'h00); drain();
    cmd(1, 1, 2'b11, 0, 0); tick();   // cur 01
    cmd(0, 0, 2'b00, 1, 0); tick();   // ignored
    cmd(0, 0, 2'b00, 0, 1);
    sb("full_top", K_NXT, 8'h00); drain();
    repeat (256) tick();
    sb("full_drained", K_EMP, 8'h01); drain();

    // Replay after done
    reset_dut();
    load_three();
    cmd(0, 0, 2'b00, 1, 0); tick();   // push after done: ignored
    cmd(0, 0, 2'b00, 0, 0);
    sb("frz_emp", K_EMP, 8'h00); drain();
    run = 1'b1;
    cmd(1, 0, 2'b00, 0, 1);
    sb("rp_nxt0", K_NXT, 8'h00); drain();
    tick(); sb("rp_cur1", K_CUR, 8'h00); sb("rp_nxt1", K_NXT, 8'h01); drain();
    tick(); sb("rp_cur2", K_CUR, 8'h01); sb("rp_nxt2", K_NXT, 8'h02);
    sb("rp_emp2", K_EMP, 8'h00); drain();
    tick(); sb("rp_cur3", K_CUR, 8'h02); sb("rp_emp3", K_EMP, 8'h01);
    sb("rp_nxt3", K_NXT, 8'h00); drain();
    tick(); sb("rp_cur4", K_CUR, 8'h00); drain();

    // Asynchronous reset mid-replay
    reset_dut();
    load_three();
    run = 1'b1;
    cmd(1, 0, 2'b00, 0, 1);
    tick(); tick();
    sb("mid_cur", K_CUR, 8'h01); drain();
    rst = 1'b0;
    #1;
    sb("arst_cur", K_CUR, 8'h00); sb("arst_emp", K_EMP, 8'h01); drain();
    rst = 1'b1;
    run = 1'b0;
    cmd(1, 1, 2'b01, 1, 0); tick();   // store 00, cur 10
    cmd(0, 0, 2'b00, 1, 0); tick();   // store 10
    cmd(0, 0, 2'b00, 0, 1);
    sb("post_emp", K_EMP, 8'h00); sb("post_nxt", K_NXT, 8'h10); drain();
    cmd(0, 0, 2'b00, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
